// File: rtl/cla_multiword_sched_if.sv
// Request/response bundle for the multiword CLA scheduler.
// Two requester channels plus one shared response channel.
interface cla_multiword_sched_if #(
    parameter int WORDS = 4
);
    localparam int N = 32 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_sub;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_sub;
    logic         req1_cin;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [N-1:0] resp_sum;
    logic         resp_cout;
    logic         resp_ovf;
    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        output req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, busy
    );
endinterface

// File: rtl/cla_multiword_sched.sv
// Serial WORDS*32-bit add/sub on one shared 32-bit CLA slice,
// round-robin between two requesters, carry chained through a register.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g, p;
    logic [7:0]  gg, gp;
    logic        gc, cc;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit group generate/propagate, group carries skip across groups
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    always_comb begin
        sum = '0;
        gc  = cin;
        cc  = cin;
        for (int k = 0; k < 8; k++) begin
            cc = gc;
            for (int i = 0; i < 4; i++) begin
                sum[4*k+i] = p[4*k+i] ^ cc;
                cc = g[4*k+i] | (p[4*k+i] & cc);
            end
            gc = gg[k] | (gp[k] & gc);
        end
        cout = gc;
    end
endmodule

module cla_multiword_sched #(
    parameter int WORDS = 4,
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    cla_multiword_sched_if.slave bus
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           id_q, id_d;
    logic           pref_q, pref_d;
    logic           valid_q, valid_d;
    logic           gnt0, gnt1, sel_sub;
    logic [WIDTH-1:0] cla_sum;
    logic           cla_cout;

    // pref_q names the requester that wins a tie
    assign gnt0 = !rst && state_q == IDLE && bus.req0_valid
                && (!bus.req1_valid || !pref_q);
    assign gnt1 = !rst && state_q == IDLE && bus.req1_valid
                && (!bus.req0_valid || pref_q);

    CLA_32bit u_cla (
        .a    (a_q[idx_q*WIDTH +: WIDTH]),
        .b    (b_q[idx_q*WIDTH +: WIDTH]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        id_d    = id_q;
        pref_d  = pref_q;
        valid_d = valid_q;
        sel_sub = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    sel_sub = gnt1 ? bus.req1_sub : bus.req0_sub;
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = (gnt1 ? bus.req1_b : bus.req0_b) ^ {N{sel_sub}};
                    carry_d = sel_sub | (gnt1 ? bus.req1_cin : bus.req0_cin);
                    id_d    = gnt1;
                    pref_d  = !gnt1;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*WIDTH +: WIDTH] = cla_sum;
                carry_d = cla_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            pref_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            pref_q  <= pref_d;
            valid_q <= valid_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = valid_q & carry_q;
    assign bus.resp_ovf   = valid_q & (a_q[N-1] == b_q[N-1])
                          & (sum_q[N-1] != a_q[N-1]);
    assign bus.busy       = state_q != IDLE;
endmodule
